// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite responder fronting a simple dual-port RAM: writes drive port A, reads drive port B.
// Optional macro AXI_RAM_SLVERR_EN: out-of-range addresses answer SLVERR instead of aliasing.
module axi_lite_ram_slave #(
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned DATA_W     = 1,
    parameter int unsigned AXI_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ADDR_W-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [AXI_ADDR_W-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  ram_wea,
    output logic [ADDR_W-1:0]     ram_addra,
    output logic [DATA_W-1:0]     ram_dina,
    output logic [ADDR_W-1:0]     ram_addrb,
    input  logic [DATA_W-1:0]     ram_doutb
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} rstate_t;

    wstate_t           wstate;
    rstate_t           rstate;
    logic [ADDR_W-1:0] aw_idx;
    logic              aw_legal;
    logic [DATA_W-1:0] w_data;
    logic              w_en;
    logic              ar_legal;

    logic aw_legal_c;
    logic ar_legal_c;
    logic aw_hs_c;
    logic w_hs_c;
    logic unused_bits;

`ifdef AXI_RAM_SLVERR_EN
    assign aw_legal_c = (s_awaddr[AXI_ADDR_W-1:ADDR_W+2] == '0);
    assign ar_legal_c = (s_araddr[AXI_ADDR_W-1:ADDR_W+2] == '0);
`else
    assign aw_legal_c = 1'b1;
    assign ar_legal_c = 1'b1;
`endif

    assign aw_hs_c     = s_awvalid && s_awready;
    assign w_hs_c      = s_wvalid && s_wready;
    // Byte lanes above the RAM word, strobes other than lane 0 and addr[1:0] are don't-cares.
    assign unused_bits = ^{s_wdata, s_wstrb, s_awaddr, s_araddr};

    // Write path: collect AW and W in any order, pulse port A once, then hold B until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate    <= W_IDLE;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
            aw_idx    <= '0;
            aw_legal  <= 1'b0;
            w_data    <= '0;
            w_en      <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs_c) begin
                        aw_idx    <= s_awaddr[ADDR_W+1:2];
                        aw_legal  <= aw_legal_c;
                        s_awready <= 1'b0;
                    end
                    if (w_hs_c) begin
                        w_data   <= s_wdata[DATA_W-1:0];
                        w_en     <= s_wstrb[0];
                        s_wready <= 1'b0;
                    end
                    // Either half may arrive this cycle or may already be held.
                    if ((aw_hs_c || !s_awready) && (w_hs_c || !s_wready)) begin
                        wstate    <= W_EXEC;
                        ram_addra <= aw_hs_c ? s_awaddr[ADDR_W+1:2] : aw_idx;
                        ram_dina  <= w_hs_c ? s_wdata[DATA_W-1:0] : w_data;
                        ram_wea   <= (aw_hs_c ? aw_legal_c : aw_legal) &&
                                     (w_hs_c ? s_wstrb[0] : w_en);
                    end
                end
                W_EXEC: begin
                    ram_wea  <= 1'b0;
                    s_bvalid <= 1'b1;
                    s_bresp  <= aw_legal ? RESP_OKAY : RESP_SLVERR;
                    wstate   <= W_RESP;
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        s_bresp   <= RESP_OKAY;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                        wstate    <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read path: address to port B, capture the word a cycle later, hold R until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate    <= R_IDLE;
            s_arready <= 1'b1;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
            ram_addrb <= '0;
            ar_legal  <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s_arvalid) begin
                        ram_addrb <= s_araddr[ADDR_W+1:2];
                        ar_legal  <= ar_legal_c;
                        s_arready <= 1'b0;
                        rstate    <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // A same-cycle port-A write lands at this edge, so the old word is captured.
                    s_rdata  <= ar_legal ? 32'(ram_doutb) : 32'd0;
                    s_rresp  <= ar_legal ? RESP_OKAY : RESP_SLVERR;
                    s_rvalid <= 1'b1;
                    rstate   <= R_RESP;
                end
                R_RESP: begin
                    if (s_rready) begin
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                        rstate    <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Scoreboard bench for axi_lite_ram_slave with a behavioural RAM bank on ports A/B.
// Expectations follow AXI_RAM_SLVERR_EN when it is defined.
module tb_axi_lite_ram_slave;

`ifdef AXI_RAM_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [7:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        ram_wea;
    logic [1:0]  ram_addra;
    logic [0:0]  ram_dina;
    logic [1:0]  ram_addrb;
    logic [0:0]  ram_doutb;

    bit mem [0:3];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [31:0] bq_resp [$];
    logic [31:0] rq_data [$];
    logic [31:0] rq_resp [$];

    axi_lite_ram_slave #(.ADDR_W(2), .DATA_W(1), .AXI_ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM bank: synchronous write on A, combinational read on B.
    always @(posedge clk) if (ram_wea) mem[ram_addra] <= ram_dina;
    assign ram_doutb = mem[ram_addrb];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT output with no expected entry (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input logic [7:0] a);
        return !SLVERR_EN || (a[7:4] == 4'h0);
    endfunction

    task automatic wait_b_idle();
        for (int i = 0; i < 20 && s_bvalid; i++) tick();
        check("b_timeout", 32'(s_bvalid), 32'd0);
    endtask

    task automatic wait_r_idle();
        for (int i = 0; i < 20 && s_rvalid; i++) tick();
        check("r_timeout", 32'(s_rvalid), 32'd0);
    endtask

    // lead = cycles by which W precedes AW (0 = same cycle).
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
        bit ok;
        bit we;
        ok = legal(addr);
        we = ok && strb[0];
        if (we) begin
            wq_addr.push_back(32'(addr[3:2]));
            wq_data.push_back(32'(data[0]));
        end
        bq_resp.push_back(ok ? 32'd0 : 32'd2);
        s_wdata = data;
        s_wstrb = strb;
        s_awaddr = addr;
        if (lead > 0) begin
            s_wvalid = 1'b1;
            tick();
            s_wvalid = 1'b0;
            check("w_ready_drop", 32'(s_wready), 32'd0);
            check("aw_ready_hold", 32'(s_awready), 32'd1);
            repeat (lead - 1) tick();
            s_awvalid = 1'b1;
            tick();
            s_awvalid = 1'b0;
        end else begin
            s_awvalid = 1'b1;
            s_wvalid = 1'b1;
            tick();
            s_awvalid = 1'b0;
            s_wvalid = 1'b0;
        end
        check("wea_lat1", 32'(ram_wea), 32'(we));
        tick();
        check("bvalid_lat2", 32'(s_bvalid), 32'd1);
        wait_b_idle();
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [31:0] word, input bit wait_done);
        bit ok;
        ok = legal(addr);
        rq_data.push_back(ok ? word : 32'd0);
        rq_resp.push_back(ok ? 32'd0 : 32'd2);
        s_araddr = addr;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("r_lat1", 32'(s_rvalid), 32'd0);
        check("ar_ready_drop", 32'(s_arready), 32'd0);
        tick();
        check("r_lat2", 32'(s_rvalid), 32'd1);
        if (wait_done) wait_r_idle();
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b1;
        s_araddr = '0; s_arvalid = 1'b0;
        s_rready = 1'b1;

        // Monitor: every port-A pulse, B beat and R beat is matched against the queues.
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (ram_wea) begin
                        if (wq_addr.size() == 0) unexpected("wea_unexpected");
                        else begin
                            check("wea_addr", 32'(ram_addra), wq_addr.pop_front());
                            check("wea_data", 32'(ram_dina), wq_data.pop_front());
                        end
                    end
                    if (s_bvalid && s_bready) begin
                        if (bq_resp.size() == 0) unexpected("b_unexpected");
                        else check("bresp", 32'(s_bresp), bq_resp.pop_front());
                    end
                    if (s_rvalid && s_rready) begin
                        if (rq_data.size() == 0) unexpected("r_unexpected");
                        else begin
                            check("rdata", s_rdata, rq_data.pop_front());
                            check("rresp", 32'(s_rresp), rq_resp.pop_front());
                        end
                    end
                end
            end
        join_none

        repeat (2) tick();
        check("rst_awready", 32'(s_awready), 32'd1);
        check("rst_wready", 32'(s_wready), 32'd1);
        check("rst_arready", 32'(s_arready), 32'd1);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_wea", 32'(ram_wea), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Reset during W_EXEC: the write is dropped with no response.
        s_awaddr = 8'h08; s_wdata = 32'd1; s_wstrb = 4'h1;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("pre_rst_wea", 32'(ram_wea), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_wea", 32'(ram_wea), 32'd0);
        check("midrst_bvalid", 32'(s_bvalid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        check("post_rst_awready", 32'(s_awready), 32'd1);
        check("post_rst_wready", 32'(s_wready), 32'd1);
        check("post_rst_arready", 32'(s_arready), 32'd1);
        repeat (3) tick();
        check("post_rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_no_write", 32'(mem[2]), 32'd0);

        // Same-cycle AW+W, then read back.
        do_write(8'h08, 32'd1, 4'h1, 0);
        do_read(8'h08, 32'd1, 1'b1);

        // W three cycles ahead of AW; then a strobe-less write that must not land.
        do_write(8'h00, 32'd1, 4'h1, 3);
        do_read(8'h00, 32'd1, 1'b1);
        do_write(8'h00, 32'd0, 4'h0, 0);
        do_read(8'h00, 32'd1, 1'b1);
        do_read(8'h0B, 32'd1, 1'b1);

        // R stalled by rready=0 while a write to 0x0C completes.
        s_rready = 1'b0;
        do_read(8'h08, 32'd1, 1'b0);
        do_write(8'h0C, 32'd1, 4'h1, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_rvalid", 32'(s_rvalid), 32'd1);
            check("stall_rdata", s_rdata, 32'd1);
            tick();
        end
        s_rready = 1'b1;
        wait_r_idle();
        do_read(8'h0C, 32'd1, 1'b1);

        // Read in R_FETCH during the write pulse to the same word sees the old value.
        wq_addr.push_back(32'd1); wq_data.push_back(32'd1);
        bq_resp.push_back(32'd0);
        rq_data.push_back(32'd0); rq_resp.push_back(32'd0);
        s_awaddr = 8'h04; s_wdata = 32'd1; s_wstrb = 4'h1; s_araddr = 8'h04;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check("col_wea", 32'(ram_wea), 32'd1);
        check("col_addrb", 32'(ram_addrb), 32'd1);
        tick();
        check("col_bvalid", 32'(s_bvalid), 32'd1);
        check("col_rvalid", 32'(s_rvalid), 32'd1);
        check("col_rdata_old", s_rdata, 32'd0);
        wait_b_idle();
        wait_r_idle();
        do_read(8'h04, 32'd1, 1'b1);

        // 0x14: SLVERR when range-checked, otherwise aliases onto word 1.
        do_write(8'h14, 32'hFFFF_FFFE, 4'hF, 0);
        do_read(8'h14, 32'd0, 1'b1);
        do_read(8'h04, SLVERR_EN ? 32'd1 : 32'd0, 1'b1);

        repeat (4) tick();
        check("wq_drained", 32'(wq_addr.size()), 32'd0);
        check("bq_drained", 32'(bq_resp.size()), 32'd0);
        check("rq_drained", 32'(rq_data.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
